operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Front-end stage for the lab 4-bit signed adder/subtractor datapath. It debounces the ENTER push-button and steps through a fixed entry sequence: operand A, operand B, operation. Each step latches the slide switches. It then presents registered operands, the subtract select and a valid flag to the downstream adder/HEX display stage. Downstream consumes `operand_a`, `operand_b` and `subtract` only while `result_valid` is high.

## Interface
- `DEBOUNCE_CYCLES`, default 500000, consecutive stable clocks required to accept a button level change (10 ms at 50 MHz). Legal range 2..2^20-1.
- `MAX10_CLK1_50`  in  1  system clock, 50 MHz, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset; one clock, reset asserted asynchronously and deasserted synchronously by board-level logic
- `SW`  in  4  slide switches, two's-complement value or op select, asynchronous to clock
- `KEY`  in  1  ENTER push-button, active-low (0 = pressed), asynchronous, bouncing
- `operand_a`  out  4  latched operand A, two's complement
- `operand_b`  out  4  latched operand B, two's complement
- `subtract`  out  1  1 = A−B, 0 = A+B
- `result_valid`  out  1  operands and op are complete and stable
- `stage_leds`  out  4  one-hot current state for LEDR[3:0]: bit0 GET_A, bit1 GET_B, bit2 GET_OP, bit3 SHOW

## Operation
- Synchronizer: `KEY` passes through 2 flops into `key_sync`. `SW` passes through 2 flops into `sw_sync`. All downstream logic uses only the synced values.
- Debouncer: register `key_stable` resets to 1 (released). Counter `db_cnt`, width ceil(log2(DEBOUNCE_CYCLES+1)), resets to 0.
  - When `key_sync` ≠ `key_stable`: `db_cnt` increments.
  - When `key_sync` = `key_stable`: `db_cnt` clears to 0, so any bounce restarts the count.
  - When `db_cnt` = DEBOUNCE_CYCLES−1 and a mismatch is still present, `key_stable` takes `key_sync` and `db_cnt` clears.
- Press pulse: `press` is a registered single-cycle strobe, high for the one clock after `key_stable` goes 1→0. A release (0→1) produces no strobe. A held button produces exactly one strobe.
- FSM, one-hot, 4 states. The named register is captured from `sw_sync` on the `press` cycle:
  - GET_A: `press` → `operand_a` ← `sw_sync[3:0]`, go to GET_B.
  - GET_B: `press` → `operand_b` ← `sw_sync[3:0]`, go to GET_OP.
  - GET_OP: `press` → `subtract` ← `sw_sync[0]`, `result_valid` ← 1, go to SHOW. `sw_sync[3:1]` is ignored.
  - SHOW: `press` → `result_valid` ← 0, `operand_a`, `operand_b` and `subtract` ← 0, go to GET_A.
  - No `press`: state and all data registers hold.
- No arithmetic in this block. Values pass through unmodified, 4-bit two's complement, range −8..+7.
- `stage_leds` is a direct copy of the one-hot state register.
- Illegal one-hot encoding recovers to GET_A with all outputs cleared on the next clock.

## Timing
- Reset values while `reset_n` = 0: `operand_a` = 0, `operand_b` = 0, `subtract` = 0, `result_valid` = 0, `stage_leds` = 4'b0001. Synchronizers = 1 (KEY) and 0 (SW), `key_stable` = 1, `db_cnt` = 0, `press` = 0. Takes effect immediately and asynchronously.
- Reset asserted mid-sequence, including SHOW: all captured operands are discarded and the block returns to GET_A. The first press after reset deassertion captures A.
- Press latency: let edge 0 be the first clock edge that samples `KEY` = 0, with no bounce after it.
  - `key_sync` = 0 after edge 1.
  - `key_stable` = 0 after edge 1+DEBOUNCE_CYCLES.
  - `press` = 1 after edge 2+DEBOUNCE_CYCLES.
  - State, data registers and outputs update at edge 3+DEBOUNCE_CYCLES.
- `SW` sampled is the `sw_sync` value at the capture edge. Switch changes at any other time have no effect.
- `result_valid` rises in the same cycle that `subtract` is loaded. `operand_a` and `operand_b` are stable ≥1 cycle before that.
- `result_valid` falls in the same cycle the operands clear. Downstream must not sample when `result_valid` = 0.
- Minimum spacing between accepted presses: 2·DEBOUNCE_CYCLES clocks (press and release both debounced).

## Test plan
Use DEBOUNCE_CYCLES = 4 in simulation.
- Reset: hold `reset_n` = 0 with `KEY` = 0 → all outputs 0, `stage_leds` = 0001. Release reset with `KEY` held low → no press until a release followed by a new press.
- Clean sequence: SW = 0011, press; SW = 1110, press; SW = 0001, press → `operand_a` = 3, `operand_b` = −2 (1110), `subtract` = 1, `result_valid` = 1, `stage_leds` = 1000. Each capture occurs exactly 7 edges after `KEY` is sampled low.
- Bounce rejection: `KEY` toggles 0/1 every 2 clocks for 20 clocks, then settles at 0 → exactly one capture, no state advance during the bounce. A single 3-clock low glitch → no capture.
- Wrap: from SHOW, press → `result_valid` = 0, operands 0, `stage_leds` = 0001. The next press captures a new A.
- Mid-operation reset: in GET_OP with A = 7, B = −8 loaded, pulse `reset_n` low for 1 ns between edges → outputs clear immediately, `stage_leds` = 0001.
- Held button and switch change: hold KEY low for 100 clocks in GET_A while toggling SW → one capture of the SW value present at the capture edge, state advances only to GET_B.

Source files
------------

// File: rtl/operand_sequencer.sv
// Entry front-end for the 4-bit adder/subtractor: debounces ENTER and steps A -> B -> op -> show,
// latching the synchronized slide switches at each accepted press.
module operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       MAX10_CLK1_50,
   input  logic       reset_n,
   input  logic [3:0] SW,
   input  logic       KEY,
   output logic [3:0] operand_a,
   output logic [3:0] operand_b,
   output logic       subtract,
   output logic       result_valid,
   output logic [3:0] stage_leds
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [3:0] {
      GET_A  = 4'b0001,
      GET_B  = 4'b0010,
      GET_OP = 4'b0100,
      SHOW   = 4'b1000
   } state_t;

   logic [1:0]       key_meta;
   logic [3:0]       sw_meta;
   logic [3:0]       sw_sync;
   logic             key_sync;
   logic             key_stable;
   logic             key_stable_d;
   logic [CNT_W-1:0] db_cnt;
   logic             press;
   logic [1:0]       prime;
   logic [CNT_W-1:0] arm_cnt;
   logic             armed;

   state_t     state;
   state_t     state_next;
   logic [3:0] a_next;
   logic [3:0] b_next;
   logic       sub_next;
   logic       valid_next;

   assign key_sync = key_meta[1];

   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         key_meta <= '1;
         sw_meta  <= '0;
         sw_sync  <= '0;
      end else begin
         key_meta <= {key_meta[0], KEY};
         sw_meta  <= SW;
         sw_sync  <= sw_meta;
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         key_stable <= 1'b1;
         db_cnt     <= '0;
      end else if (key_sync == key_stable) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         key_stable <= key_sync;
         db_cnt     <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // A button held through reset must be seen released (debounced) before any
   // press is honoured; the sync chain's reset value must not count as a release.
   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         prime   <= '0;
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         prime <= {prime[0], 1'b1};
         if (!armed) begin
            if (prime[1] && key_sync) begin
               if (arm_cnt == DB_LAST) armed <= 1'b1;
               else                    arm_cnt <= arm_cnt + 1'b1;
            end else begin
               arm_cnt <= '0;
            end
         end
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         key_stable_d <= 1'b1;
         press        <= 1'b0;
      end else begin
         key_stable_d <= key_stable;
         press        <= armed & key_stable_d & ~key_stable;
      end
   end

   always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
         state        <= GET_A;
         operand_a    <= '0;
         operand_b    <= '0;
         subtract     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         state        <= state_next;
         operand_a    <= a_next;
         operand_b    <= b_next;
         subtract     <= sub_next;
         result_valid <= valid_next;
      end
   end

   always_comb begin
      state_next = state;
      a_next     = operand_a;
      b_next     = operand_b;
      sub_next   = subtract;
      valid_next = result_valid;
      case (state)
         GET_A: if (press) begin
            a_next     = sw_sync;
            state_next = GET_B;
         end
         GET_B: if (press) begin
            b_next     = sw_sync;
            state_next = GET_OP;
         end
         GET_OP: if (press) begin
            sub_next   = sw_sync[0];
            valid_next = 1'b1;
            state_next = SHOW;
         end
         SHOW: if (press) begin
            a_next     = '0;
            b_next     = '0;
            sub_next   = 1'b0;
            valid_next = 1'b0;
            state_next = GET_A;
         end
         default: begin
            a_next     = '0;
            b_next     = '0;
            sub_next   = 1'b0;
            valid_next = 1'b0;
            state_next = GET_A;
         end
      endcase
   end

   assign stage_leds = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized bench for operand_sequencer: press/bounce/hold stimulus checked against
// a transaction-level model of the A -> B -> op -> show entry sequence.
module tb_operand_sequencer;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key = 1'b1;
   logic [3:0] sw = '0;
   logic [3:0] op_a, op_b, leds;
   logic       sub, valid;

   int n_checks = 0;
   int n_fails = 0;

   int         m_stage;
   logic [3:0] m_a, m_b;
   logic       m_sub, m_valid;
   logic [3:0] hist [0:100];

   always #5 clk = ~clk;

   operand_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
      .MAX10_CLK1_50(clk),
      .reset_n      (rst_n),
      .SW           (sw),
      .KEY          (key),
      .operand_a    (op_a),
      .operand_b    (op_b),
      .subtract     (sub),
      .result_valid (valid),
      .stage_leds   (leds)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   function automatic logic [3:0] stage_onehot(input int s);
      return 4'(1 << s);
   endfunction

   task automatic model_reset();
      m_stage = 0; m_a = '0; m_b = '0; m_sub = 1'b0; m_valid = 1'b0;
   endtask

   task automatic model_press(input logic [3:0] v);
      case (m_stage)
         0: m_a = v;
         1: m_b = v;
         2: begin m_sub = v[0]; m_valid = 1'b1; end
         default: begin m_a = '0; m_b = '0; m_sub = 1'b0; m_valid = 1'b0; end
      endcase
      m_stage = (m_stage + 1) % 4;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".a"},     {4'b0, op_a},  {4'b0, m_a});
      chk({tag, ".b"},     {4'b0, op_b},  {4'b0, m_b});
      chk({tag, ".sub"},   {7'b0, sub},   {7'b0, m_sub});
      chk({tag, ".valid"}, {7'b0, valid}, {7'b0, m_valid});
      chk({tag, ".leds"},  {4'b0, leds},  {4'b0, stage_onehot(m_stage)});
   endtask

   // Glitches shorter than D must be ignored; the clean press must land exactly 3+D edges after KEY goes low.
   task automatic press(input logic [3:0] v, input int n_glitch, input int glitch_len);
      int edge_at;
      logic [3:0] want;
      sw = v;
      for (int g = 0; g < n_glitch; g++) begin
         key = 1'b0; cyc(glitch_len);
         key = 1'b1; cyc(2);
      end
      if (n_glitch > 0) chk("bounce_hold", {4'b0, leds}, {4'b0, stage_onehot(m_stage)});
      want = stage_onehot((m_stage + 1) % 4);
      key = 1'b0;
      edge_at = -1;
      for (int n = 0; n < 40 && edge_at < 0; n++) begin
         @(posedge clk); @(negedge clk);
         if (leds === want) edge_at = n;
      end
      chk("latency", 8'(edge_at), 8'(3 + D));
      model_press(v);
      check_outputs("press");
      cyc($urandom_range(0, 6));
      key = 1'b1;
      sw = 4'($urandom);
      cyc(2 * D + 4);
      check_outputs("after_release");
   endtask

   initial begin
      int first;
      int changes;
      logic [3:0] prev;

      rst_n = 1'b0; key = 1'b0; sw = 4'($urandom);
      model_reset();
      cyc(3);
      check_outputs("reset");
      rst_n = 1'b1;
      cyc(30);
      check_outputs("held_thru_reset");
      key = 1'b1;
      cyc(2 * D + 6);
      check_outputs("released");

      press(4'b0011, 0, 1);
      press(4'b1110, 0, 1);
      press(4'b0001, 0, 1);
      chk("seq.a", {4'b0, op_a}, 8'h03);
      chk("seq.b", {4'b0, op_b}, 8'h0E);
      chk("seq.leds", {4'b0, leds}, 8'h08);

      press(4'($urandom), 0, 1);
      press(4'($urandom), 5, 2);

      key = 1'b0; cyc(3); key = 1'b1; cyc(2 * D + 4);
      check_outputs("glitch3");

      for (int i = 0; i < 16; i++)
         press(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, D - 1)));

      while (m_stage != 0) press(4'($urandom), 0, 1);
      press(4'd7, 1, 1);
      press(4'b1000, 0, 1);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs("async_reset");
      rst_n = 1'b1;
      @(negedge clk);
      cyc(2 * D + 6);
      check_outputs("post_reset");
      press(4'b0101, 0, 1);
      chk("post_reset_capture_a", {4'b0, op_a}, 8'h05);

      while (m_stage != 0) press(4'($urandom), 0, 1);
      key = 1'b0;
      hist[0] = 4'($urandom);
      sw = hist[0];
      first = -1;
      changes = 0;
      prev = 4'b0001;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk); @(negedge clk);
         if (leds !== prev) begin
            changes++;
            if (first < 0) first = n;
            prev = leds;
         end
         hist[n + 1] = 4'($urandom);
         sw = hist[n + 1];
      end
      chk("held.latency", 8'(first), 8'(3 + D));
      chk("held.changes", 8'(changes), 8'd1);
      model_press(hist[1 + D]);
      check_outputs("held");
      key = 1'b1;
      cyc(2 * D + 4);
      check_outputs("held_release");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
